// File: rtl/qmat_parser.sv
// qmat_parser: parses the quantization-matrix section of a frame header.
// Luma and/or chroma 8x8 matrices arrive as raster-order bytes over a
// valid/ready stream. A missing chroma matrix is copied from luma, and any
// zero coefficient raises a sticky error flag.
module qmat_parser (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        load_luma,
    input  logic        load_chroma,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [31:0] Y_QMAT [8][8],
    output logic [31:0] C_QMAT [8][8],
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_Y = 3'd1,
        LOAD_C = 3'd2,
        COPY_C = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t     r_state;
    logic [5:0] r_idx;
    logic       r_in_ready;
    logic       r_busy;
    logic       r_done;
    logic       r_error;
    logic       r_chroma;

    logic       w_accept;
    logic       w_init;
    logic       w_y_wr;
    logic       w_c_wr;
    logic       w_copy;
    logic       w_last;

    // A byte is consumed only on a handshake; in_ready is already gated by state.
    assign w_accept = in_valid && r_in_ready;
    assign w_init   = (r_state == IDLE) && start;
    assign w_y_wr   = w_accept && (r_state == LOAD_Y);
    assign w_c_wr   = w_accept && (r_state == LOAD_C);
    assign w_copy   = (r_state == COPY_C);
    assign w_last   = (r_idx == 6'd63);

    assign in_ready = r_in_ready;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;

    // Control FSM with registered in_ready/busy/done/error.
    // Only the chroma flag needs latching: the luma flag is consumed immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_idx      <= 6'd0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_chroma   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_chroma <= load_chroma;
                        r_error  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_idx    <= 6'd0;
                        if (load_luma) begin
                            r_state    <= LOAD_Y;
                            r_in_ready <= 1'b1;
                        end else if (load_chroma) begin
                            r_state    <= LOAD_C;
                            r_in_ready <= 1'b1;
                        end else begin
                            r_state <= COPY_C;
                        end
                    end
                end
                LOAD_Y: begin
                    if (w_accept) begin
                        if (in_data == 8'd0) begin
                            r_error <= 1'b1;
                        end
                        if (w_last) begin
                            r_idx <= 6'd0;
                            if (r_chroma) begin
                                r_state <= LOAD_C;
                            end else begin
                                r_state    <= COPY_C;
                                r_in_ready <= 1'b0;
                            end
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                LOAD_C: begin
                    if (w_accept) begin
                        if (in_data == 8'd0) begin
                            r_error <= 1'b1;
                        end
                        if (w_last) begin
                            r_idx      <= 6'd0;
                            r_state    <= FINISH;
                            r_in_ready <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                        end
                    end
                end
                COPY_C: begin
                    r_state <= FINISH;
                    r_done  <= 1'b1;
                end
                FINISH: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // One luma and one chroma coefficient register per matrix position.
    for (genvar gi = 0; gi < 8; gi++) begin : g_row
        for (genvar gj = 0; gj < 8; gj++) begin : g_col
            localparam logic [5:0] ELEM_IDX = 6'(gi * 8 + gj);

            logic [7:0] r_y;
            logic [7:0] r_c;
            logic       w_hit;

            assign w_hit = (r_idx == ELEM_IDX);

            // Luma element: defaults to 4 on start, overwritten by its raster byte.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_y <= 8'd4;
                end else if (w_init) begin
                    r_y <= 8'd4;
                end else if (w_y_wr && w_hit) begin
                    r_y <= in_data;
                end
            end

            // Chroma element: loaded from the stream, or mirrored from luma.
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_c <= 8'd4;
                end else if (w_init) begin
                    r_c <= 8'd4;
                end else if (w_c_wr && w_hit) begin
                    r_c <= in_data;
                end else if (w_copy) begin
                    r_c <= r_y;
                end
            end

            assign Y_QMAT[gi][gj] = {24'd0, r_y};
            assign C_QMAT[gi][gj] = {24'd0, r_c};
        end
    end

endmodule

// File: tb/tb_qmat_parser.sv
// tb_qmat_parser: randomized self-checking bench for qmat_parser.
// Expected matrices come from a frame-level model: the streamed byte list
// is split into luma/chroma sections according to the start flags.
module tb_qmat_parser;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        load_luma;
    logic        load_chroma;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [31:0] y_qmat [8][8];
    logic [31:0] c_qmat [8][8];
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    byte unsigned frame_q[$];
    logic [7:0]   exp_y [64];
    logic [7:0]   exp_c [64];
    int           bad_idx;
    logic [31:0]  bad_act;
    logic [31:0]  bad_req;

    qmat_parser dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .load_luma  (load_luma),
        .load_chroma(load_chroma),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .Y_QMAT     (y_qmat),
        .C_QMAT     (c_qmat),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    // Frame model: luma takes the first 64 bytes when present, chroma the
    // next 64; absent chroma mirrors luma; absent matrices stay at 4.
    function automatic void build_model(input bit ll, input bit lc);
        int base;
        base = 0;
        for (int k = 0; k < 64; k++) begin
            exp_y[k] = 8'd4;
            exp_c[k] = 8'd4;
        end
        if (ll) begin
            for (int k = 0; k < 64; k++) exp_y[k] = frame_q[k];
            base = 64;
        end
        if (lc) begin
            for (int k = 0; k < 64; k++) exp_c[k] = frame_q[base + k];
        end else begin
            for (int k = 0; k < 64; k++) exp_c[k] = exp_y[k];
        end
    endfunction

    // Counts DUT elements differing from the model; remembers the first one.
    function automatic int mat_bad(input bit chroma);
        int n;
        logic [31:0] act;
        logic [31:0] req;
        n = 0;
        for (int k = 0; k < 64; k++) begin
            act = chroma ? c_qmat[k / 8][k % 8] : y_qmat[k / 8][k % 8];
            req = {24'd0, (chroma ? exp_c[k] : exp_y[k])};
            if (act !== req) begin
                if (n == 0) begin
                    bad_idx = k;
                    bad_act = act;
                    bad_req = req;
                end
                n++;
            end
        end
        return n;
    endfunction

    function automatic void fill_random(input int n);
        frame_q.delete();
        for (int k = 0; k < n; k++) frame_q.push_back(8'($urandom_range(255, 1)));
    endfunction

    // Issues start, streams frame_q with random gaps, and watches for done.
    // Junk start/flags while busy and junk in_valid while not ready must be ignored.
    task automatic run_frame(input bit ll, input bit lc, input int gap,
                             output int lat, output int acc, output int ready_cnt,
                             output int err_first, output bit err_drop, output bit err_at_done);
        int cyc;
        int last;
        bit seen;
        lat = -1; acc = 0; ready_cnt = 0; err_first = -1;
        err_drop = 1'b0; err_at_done = 1'b0; seen = 1'b0;
        @(negedge clock);
        start = 1'b1; load_luma = ll; load_chroma = lc; in_valid = 1'b0; in_data = 8'($urandom);
        last = 0;
        cyc = 0;
        while (cyc < 2000) begin
            @(negedge clock);
            cyc++;
            start = 1'b0;
            if (in_ready) ready_cnt++;
            if (error) begin
                if (!seen) err_first = acc;
                seen = 1'b1;
            end else if (seen) begin
                err_drop = 1'b1;
            end
            if (done) begin
                lat = cyc - last;
                err_at_done = error;
                break;
            end
            start       = 1'($urandom_range(1));
            load_luma   = 1'($urandom_range(1));
            load_chroma = 1'($urandom_range(1));
            if (in_ready && acc < frame_q.size() && int'($urandom_range(99)) >= gap) begin
                in_valid = 1'b1;
                in_data  = frame_q[acc];
                acc++;
                last = cyc;
            end else begin
                in_valid = in_ready ? 1'b0 : 1'($urandom_range(1));
                in_data  = 8'($urandom);
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        $display("frame ll=%0d lc=%0d gap=%0d bytes=%0d done_latency=%0d error=%0d",
                 ll, lc, gap, acc, lat, err_at_done);
    endtask

    task automatic test_reset();
        int n;
        build_model(1'b0, 1'b0);
        #12;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", in_ready); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", error); end
        n = mat_bad(1'b0);
        checks++; if (n !== 0) begin failures++; $display("FAIL reset_y: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
        n = mat_bad(1'b1);
        checks++; if (n !== 0) begin failures++; $display("FAIL reset_c: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_load();
        int lat, acc, rdy, ef, n, rdy_idle;
        bit ed, ead;
        frame_q.delete();
        for (int k = 1; k <= 128; k++) frame_q.push_back(8'(k));
        build_model(1'b1, 1'b1);
        run_frame(1'b1, 1'b1, 0, lat, acc, rdy, ef, ed, ead);
        checks++; if (lat !== 1) begin failures++; $display("FAIL full_latency: got %0d want 1", lat); end
        checks++; if (acc !== 128) begin failures++; $display("FAIL full_bytes: got %0d want 128", acc); end
        checks++; if (ead !== 1'b0) begin failures++; $display("FAIL full_error: got %b want 0", ead); end
        n = mat_bad(1'b0);
        checks++; if (n !== 0) begin failures++; $display("FAIL full_y: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
        n = mat_bad(1'b1);
        checks++; if (n !== 0) begin failures++; $display("FAIL full_c: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
        // Matrices must hold in IDLE even with stray valid bytes on the bus.
        rdy_idle = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (in_ready || busy) rdy_idle++;
            in_valid = 1'($urandom_range(1));
            in_data  = 8'($urandom);
        end
        in_valid = 1'b0;
        checks++; if (rdy_idle !== 0) begin failures++; $display("FAIL idle_ready_busy: got %0d cycles want 0", rdy_idle); end
        n = mat_bad(1'b0) + mat_bad(1'b1);
        checks++; if (n !== 0) begin failures++; $display("FAIL idle_hold: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
    endtask

    task automatic test_luma_only();
        int lat, acc, rdy, ef, n;
        bit ed, ead;
        frame_q.delete();
        for (int k = 0; k < 64; k++) frame_q.push_back(8'd16);
        build_model(1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 0, lat, acc, rdy, ef, ed, ead);
        checks++; if (lat !== 2) begin failures++; $display("FAIL luma16_latency: got %0d want 2", lat); end
        n = mat_bad(1'b0) + mat_bad(1'b1);
        checks++; if (n !== 0) begin failures++; $display("FAIL luma16_mats: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
        fill_random(64);
        build_model(1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 40, lat, acc, rdy, ef, ed, ead);
        checks++; if (lat !== 2) begin failures++; $display("FAIL luma_rand_latency: got %0d want 2", lat); end
        n = mat_bad(1'b1);
        checks++; if (n !== 0) begin failures++; $display("FAIL luma_rand_copy: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
    endtask

    task automatic test_no_load();
        int lat, acc, rdy, ef, n;
        bit ed, ead;
        frame_q.delete();
        build_model(1'b0, 1'b0);
        run_frame(1'b0, 1'b0, 0, lat, acc, rdy, ef, ed, ead);
        checks++; if (lat !== 2) begin failures++; $display("FAIL noload_latency: got %0d want 2", lat); end
        checks++; if (rdy !== 0) begin failures++; $display("FAIL noload_ready: got %0d cycles want 0", rdy); end
        n = mat_bad(1'b0) + mat_bad(1'b1);
        checks++; if (n !== 0) begin failures++; $display("FAIL noload_mats: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
    endtask

    task automatic test_gaps();
        int lat, acc, rdy, ef, n;
        bit ed, ead;
        fill_random(128);
        build_model(1'b1, 1'b1);
        for (int pass = 0; pass < 2; pass++) begin
            run_frame(1'b1, 1'b1, pass * 50, lat, acc, rdy, ef, ed, ead);
            checks++; if (lat !== 1) begin failures++; $display("FAIL gaps%0d_latency: got %0d want 1", pass, lat); end
            checks++; if (acc !== 128) begin failures++; $display("FAIL gaps%0d_bytes: got %0d want 128", pass, acc); end
            n = mat_bad(1'b0) + mat_bad(1'b1);
            checks++; if (n !== 0) begin failures++; $display("FAIL gaps%0d_mats: %0d bad, [%0d] got %0d want %0d", pass, n, bad_idx, bad_act, bad_req); end
        end
        fill_random(64);
        build_model(1'b0, 1'b1);
        run_frame(1'b0, 1'b1, 50, lat, acc, rdy, ef, ed, ead);
        checks++; if (lat !== 1) begin failures++; $display("FAIL chroma_only_latency: got %0d want 1", lat); end
        n = mat_bad(1'b0) + mat_bad(1'b1);
        checks++; if (n !== 0) begin failures++; $display("FAIL chroma_only_mats: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
    endtask

    task automatic test_error();
        int lat, acc, rdy, ef, n;
        bit ed, ead;
        fill_random(128);
        frame_q[10] = 8'd0;
        build_model(1'b1, 1'b1);
        run_frame(1'b1, 1'b1, 30, lat, acc, rdy, ef, ed, ead);
        checks++; if (ef !== 11) begin failures++; $display("FAIL err_rise: after %0d bytes want 11", ef); end
        checks++; if (ed !== 1'b0) begin failures++; $display("FAIL err_sticky: dropped=%b want 0", ed); end
        checks++; if (ead !== 1'b1) begin failures++; $display("FAIL err_at_done: got %b want 1", ead); end
        n = mat_bad(1'b0);
        checks++; if (n !== 0) begin failures++; $display("FAIL err_zero_stored: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
        fill_random(64);
        build_model(1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 20, lat, acc, rdy, ef, ed, ead);
        checks++; if (ef !== -1) begin failures++; $display("FAIL err_clear: seen after %0d bytes want never", ef); end
        checks++; if (ead !== 1'b0) begin failures++; $display("FAIL err_clear_done: got %b want 0", ead); end
    endtask

    task automatic test_reset_mid();
        int lat, acc, rdy, ef, n, sent, cyc;
        bit ed, ead;
        @(negedge clock);
        start = 1'b1; load_luma = 1'b1; load_chroma = 1'b1; in_valid = 1'b0;
        sent = 0;
        cyc = 0;
        while (sent < 30 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            start = 1'b0;
            if (in_ready) begin
                in_valid = 1'b1;
                in_data  = 8'($urandom_range(255, 1));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clock);
        in_valid = 1'b0;
        checks++; if (sent !== 30) begin failures++; $display("FAIL midreset_stream: sent %0d want 30", sent); end
        #2 reset_n = 1'b0;
        #1;
        build_model(1'b0, 1'b0);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL midreset_ready: got %b want 0", in_ready); end
        n = mat_bad(1'b0) + mat_bad(1'b1);
        checks++; if (n !== 0) begin failures++; $display("FAIL midreset_mats: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midreset_wait: busy=%b want 0", busy); end
        frame_q.delete();
        run_frame(1'b0, 1'b0, 0, lat, acc, rdy, ef, ed, ead);
        checks++; if (lat !== 2) begin failures++; $display("FAIL postreset_latency: got %0d want 2", lat); end
        n = mat_bad(1'b0) + mat_bad(1'b1);
        checks++; if (n !== 0) begin failures++; $display("FAIL postreset_mats: %0d bad, [%0d] got %0d want %0d", n, bad_idx, bad_act, bad_req); end
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        load_luma   = 1'b0;
        load_chroma = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'd0;
        test_reset();
        test_full_load();
        test_luma_only();
        test_no_load();
        test_gaps();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qmat_parser.md
QMAT_PARSER -- requirements
Module: qmat_parser

Interface
REQ-001 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port: start  input  1  one-cycle request to begin parsing a frame-header matrix section; sampled only in IDLE.
REQ-004 SHALL have port: load_luma  input  1  frame-header flag: 64 luma bytes follow; sampled with start.
REQ-005 SHALL have port: load_chroma  input  1  frame-header flag: 64 chroma bytes follow (after luma, if present); sampled with start.
REQ-006 SHALL have port: in_valid  input  1  in_data holds a byte.
REQ-007 SHALL have port: in_data  input  8  matrix byte, raster order (row*8+col).
REQ-008 SHALL have port: in_ready  output  1  parser accepts a byte this cycle.
REQ-009 SHALL have port: Y_QMAT  output  32 x [8][8]  luma quantization matrix; bits [31:8] always 0.
REQ-010 SHALL have port: C_QMAT  output  32 x [8][8]  chroma quantization matrix; bits [31:8] always 0.
REQ-011 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port: done  output  1  one-cycle pulse when the matrix section is complete.
REQ-013 SHALL have port: error  output  1  sticky flag: a zero-valued coefficient was received.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD_Y, LOAD_C, COPY_C, FINISH.
REQ-015 SHALL accept a byte only on a cycle with in_valid && in_ready; no other cycle changes the byte index.
REQ-016 SHALL drive in_ready high only in LOAD_Y and LOAD_C, as a registered (not combinational from in_valid) signal.
REQ-017 SHALL use a 6-bit byte index, cleared on entry to LOAD_Y and LOAD_C; an accepted byte writes element [index[5:3]][index[2:0]] and increments the index.
REQ-018 On start in IDLE, SHALL latch load_luma/load_chroma, clear error, and load all 64 elements of both matrices with 4 in that same cycle.
REQ-019 IDLE transition on start: load_luma=1 -> LOAD_Y; else load_chroma=1 -> LOAD_C; else COPY_C.
REQ-020 LOAD_Y: on acceptance of byte index 63, SHALL go to LOAD_C if latched load_chroma=1, else COPY_C.
REQ-021 LOAD_C: on acceptance of byte index 63, SHALL go to FINISH.
REQ-022 COPY_C: SHALL copy all 64 Y_QMAT elements into C_QMAT in one cycle, then go to FINISH (luma-only or no-load case: chroma equals luma).
REQ-023 FINISH: SHALL assert done for exactly one cycle and return to IDLE.
REQ-024 SHALL ignore start in any state other than IDLE.
REQ-025 An accepted byte of value 0 SHALL be stored unchanged and SHALL set error; error is held until the next accepted start or reset.
REQ-026 in_valid with in_ready low SHALL be ignored, with no data loss tracking (the upstream holds the byte).
REQ-027 Matrix outputs SHALL hold their values in IDLE until the next accepted start.
REQ-028 Latency: last byte accepted at cycle N -> done high at cycle N+1 (LOAD_C path) or N+2 (COPY_C path).

Reset
REQ-029 On reset_n low, SHALL immediately force the state to IDLE, index to 0, in_ready/busy/done/error to 0, and all 128 matrix elements to 4.
REQ-030 A reset asserted mid-load SHALL abort the load; no partial matrix survives; after release the block waits for a new start.

Verification
REQ-031 start, load_luma=1, load_chroma=1, bytes 1..128 streamed with in_valid constantly high -> Y_QMAT[i][j]=i*8+j+1, C_QMAT[i][j]=65+i*8+j, done 1 cycle after byte 128, error=0.
REQ-032 start, load_luma=1, load_chroma=0, 64 bytes of value 16 -> Y_QMAT and C_QMAT all 16, done 2 cycles after last byte.
REQ-033 start, load_luma=0, load_chroma=0 -> in_ready never high, both matrices all 4, done pulses exactly 2 cycles after start.
REQ-034 Random in_valid gaps (about 50% duty), load_luma=1 and load_chroma=1, 128 bytes -> matrices identical to the gap-free run; byte index advances only on handshake cycles.
REQ-035 Luma byte index 10 = 0x00 -> error rises after that byte and stays high through done; next start clears it.
REQ-036 reset_n pulsed low after 30 luma bytes -> all elements 4, busy=0 asynchronously; a following start with load_luma=0 yields done with all elements 4.
